// File: rtl/mips_pkg.sv
// Shared pipeline constants and types for the register-file write path.
package mips_pkg;

    localparam int unsigned MIPS_DW = 32;
    localparam int unsigned MIPS_AW = 5;
    localparam logic [MIPS_AW-1:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic               we;
        logic [MIPS_AW-1:0] rd;
        logic [MIPS_DW-1:0] data;
    } wr_req_t;

endpackage

// File: rtl/rf_write_arbiter_if.sv
// WB, MDU and register-file write-port signals of the write arbiter.
interface rf_write_arbiter_if #(
    parameter int unsigned DW = 32,
    parameter int unsigned AW = 5
);
    logic          wb_we;
    logic [AW-1:0] wb_rd;
    logic [DW-1:0] wb_data;
    logic          mdu_valid;
    logic [AW-1:0] mdu_rd;
    logic [DW-1:0] mdu_data;
    logic          mdu_ready;
    logic          RegWrite;
    logic [AW-1:0] Write_register;
    logic [DW-1:0] Write_data;

    modport master (
        output wb_we, wb_rd, wb_data, mdu_valid, mdu_rd, mdu_data,
        input  mdu_ready, RegWrite, Write_register, Write_data
    );

    modport slave (
        input  wb_we, wb_rd, wb_data, mdu_valid, mdu_rd, mdu_data,
        output mdu_ready, RegWrite, Write_register, Write_data
    );
endinterface

// File: rtl/sync_fifo.sv
// Synchronous valid/ready FIFO; ready depends only on the registered count.
module sync_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = 37
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [W-1:0]             in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [W-1:0]             out_data,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int unsigned PW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW:0]   count_q, count_d;
    logic          push, pop;

    always_comb begin
        in_ready  = (count_q < (PW+1)'(DEPTH));
        out_valid = (count_q != '0);
        out_data  = mem_q[rd_ptr_q];
        count     = count_q;
        // A full FIFO refuses a push even when it pops in the same cycle.
        push      = in_valid && in_ready;
        pop       = out_ready && out_valid;

        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = in_data;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        count_d = count_q + (PW+1)'(push) - (PW+1)'(pop);
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end
endmodule

// File: rtl/rf_write_arbiter.sv
// Merges WB-stage and MDU writes onto one register-file port, tracking
// outstanding MDU destinations for the hazard unit.
module rf_write_arbiter #(
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned STARVE_LIMIT = 8,
    parameter int unsigned DW           = mips_pkg::MIPS_DW,
    parameter int unsigned AW           = mips_pkg::MIPS_AW
) (
    input  logic                  clk,
    input  logic                  reset,
    rf_write_arbiter_if.slave     bus,
    input  logic                  issue_valid,
    input  logic [AW-1:0]         issue_rd,
    input  logic [AW-1:0]         query_rs,
    input  logic [AW-1:0]         query_rt,
    output logic                  rs_pending,
    output logic                  rt_pending,
    output logic                  stall_req,
    output logic                  waw_err
);
    import mips_pkg::*;

    localparam int unsigned CW  = $clog2(STARVE_LIMIT + 1);
    localparam int unsigned NR  = 2 ** AW;
    localparam logic [AW-1:0] RZ = AW'(REG_ZERO);

    typedef struct packed {
        logic [AW-1:0] rd;
        logic [DW-1:0] data;
    } entry_t;

    entry_t                fifo_in, fifo_out;
    logic                  fifo_in_valid, fifo_in_ready;
    logic                  fifo_valid, fifo_pop;
    logic [$clog2(DEPTH):0] fifo_count;

    logic [NR-1:0] pending_q, pending_d;
    logic          waw_q, waw_d;
    logic [CW-1:0] starve_q, starve_d;
    logic          wb_sel, fifo_commit;

    assign fifo_in       = '{rd: bus.mdu_rd, data: bus.mdu_data};
    assign fifo_in_valid = bus.mdu_valid && !reset;

    sync_fifo #(
        .DEPTH (DEPTH),
        .W     (AW + DW)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (fifo_in_valid),
        .in_ready  (fifo_in_ready),
        .in_data   (fifo_in),
        .out_valid (fifo_valid),
        .out_ready (fifo_pop),
        .out_data  (fifo_out),
        .count     (fifo_count)
    );

    always_comb begin
        wb_sel      = bus.wb_we && (bus.wb_rd != RZ);
        // A $0 head is still popped; it just never reaches the port.
        fifo_pop    = !wb_sel && fifo_valid;
        fifo_commit = fifo_pop && (fifo_out.rd != RZ);

        bus.RegWrite       = 1'b0;
        bus.Write_register = '0;
        bus.Write_data     = '0;
        if (!reset) begin
            if (wb_sel) begin
                bus.RegWrite       = 1'b1;
                bus.Write_register = bus.wb_rd;
                bus.Write_data     = bus.wb_data;
            end else if (fifo_commit) begin
                bus.RegWrite       = 1'b1;
                bus.Write_register = fifo_out.rd;
                bus.Write_data     = fifo_out.data;
            end
        end
        bus.mdu_ready = reset || fifo_in_ready;

        rs_pending = !reset && (query_rs != RZ) && pending_q[query_rs];
        rt_pending = !reset && (query_rt != RZ) && pending_q[query_rt];
        stall_req  = !reset && (starve_q == CW'(STARVE_LIMIT));
        waw_err    = !reset && waw_q;
    end

    always_comb begin
        pending_d = pending_q;
        // Clear before set so a same-cycle issue to the same register wins.
        if (fifo_commit) begin
            pending_d[fifo_out.rd] = 1'b0;
        end
        if (issue_valid && (issue_rd != RZ)) begin
            pending_d[issue_rd] = 1'b1;
        end

        waw_d = waw_q || (wb_sel && pending_q[bus.wb_rd]);

        starve_d = starve_q;
        if ((fifo_count == '0) || fifo_pop) begin
            starve_d = '0;
        end else if (starve_q != CW'(STARVE_LIMIT)) begin
            starve_d = starve_q + CW'(1);
        end

        if (reset) begin
            pending_d = '0;
            waw_d     = 1'b0;
            starve_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        pending_q <= pending_d;
        waw_q     <= waw_d;
        starve_q  <= starve_d;
    end
endmodule

// File: tb/tb_rf_write_arbiter.sv
// Randomized self-checking bench for rf_write_arbiter against a queue-based model.
module tb_rf_write_arbiter;
    localparam int DEPTH        = 4;
    localparam int STARVE_LIMIT = 8;
    localparam int NCYC         = 3000;

    logic       clk = 1'b0;
    logic       reset;
    logic       issue_valid;
    logic [4:0] issue_rd, query_rs, query_rt;
    logic       rs_pending, rt_pending, stall_req, waw_err;

    rf_write_arbiter_if #(.DW(32), .AW(5)) bus ();

    rf_write_arbiter #(
        .DEPTH        (DEPTH),
        .STARVE_LIMIT (STARVE_LIMIT),
        .DW           (32),
        .AW           (5)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .query_rs    (query_rs),
        .query_rt    (query_rt),
        .rs_pending  (rs_pending),
        .rt_pending  (rt_pending),
        .stall_req   (stall_req),
        .waw_err     (waw_err)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%08h expected=0x%08h at t=%0t", tag, got, exp, $time);
        end
    endtask

    typedef struct {
        int          rd;
        logic [31:0] data;
    } ent_t;

    ent_t q[$];
    bit   pend[32];
    bit   waw;
    int   starve;

    initial begin
        reset           = 1'b1;
        bus.wb_we       = 1'b0;
        bus.wb_rd       = '0;
        bus.wb_data     = '0;
        bus.mdu_valid   = 1'b0;
        bus.mdu_rd      = '0;
        bus.mdu_data    = '0;
        issue_valid     = 1'b0;
        issue_rd        = '0;
        query_rs        = '0;
        query_rt        = '0;
        waw             = 0;
        starve          = 0;
        foreach (pend[i]) pend[i] = 0;

        for (int cyc = 0; cyc < NCYC; cyc++) begin
            int mode;
            @(negedge clk);
            mode = (cyc / 80) % 3;
            reset = (cyc < 3) || ($urandom_range(0, 199) == 0);
            case (mode)
                1:       bus.wb_we = ($urandom % 20) != 0;
                2:       bus.wb_we = ($urandom % 8) == 0;
                default: bus.wb_we = ($urandom % 2) != 0;
            endcase
            bus.wb_rd     = (mode == 1) ? 5'($urandom_range(1, 7)) : 5'($urandom_range(0, 7));
            bus.wb_data   = $urandom;
            bus.mdu_valid = (mode == 1) ? (($urandom % 3) != 0) : (($urandom % 2) != 0);
            bus.mdu_rd    = 5'($urandom_range(0, 7));
            bus.mdu_data  = $urandom;
            issue_valid   = ($urandom % 3) == 0;
            issue_rd      = 5'($urandom_range(0, 7));
            query_rs      = 5'($urandom_range(0, 7));
            query_rt      = 5'($urandom_range(0, 7));
            #2;

            if (reset) begin
                check_val("rst_regwrite", 32'(bus.RegWrite), 32'd0);
                check_val("rst_wreg", 32'(bus.Write_register), 32'd0);
                check_val("rst_wdata", bus.Write_data, 32'd0);
                check_val("rst_mdu_ready", 32'(bus.mdu_ready), 32'd1);
                check_val("rst_stall", 32'(stall_req), 32'd0);
                q.delete();
                foreach (pend[i]) pend[i] = 0;
                waw    = 0;
                starve = 0;
            end else begin
                bit   wb_owns, pop;
                int   size0;
                bit   e_we;
                int   e_rd;
                logic [31:0] e_data;
                ent_t head;

                size0   = q.size();
                wb_owns = bus.wb_we && (bus.wb_rd != 0);
                pop     = !wb_owns && (size0 > 0);
                e_we = 0; e_rd = 0; e_data = 0;
                if (wb_owns) begin
                    e_we = 1; e_rd = int'(bus.wb_rd); e_data = bus.wb_data;
                end else if (pop && q[0].rd != 0) begin
                    e_we = 1; e_rd = q[0].rd; e_data = q[0].data;
                end

                check_val("regwrite", 32'(bus.RegWrite), 32'(e_we));
                check_val("write_register", 32'(bus.Write_register), 32'(e_rd));
                check_val("write_data", bus.Write_data, e_data);
                check_val("mdu_ready", 32'(bus.mdu_ready), 32'(size0 < DEPTH));
                check_val("rs_pending", 32'(rs_pending), 32'(pend[query_rs]));
                check_val("rt_pending", 32'(rt_pending), 32'(pend[query_rt]));
                check_val("stall_req", 32'(stall_req), 32'(starve == STARVE_LIMIT));
                check_val("waw_err", 32'(waw_err), 32'(waw));

                if (wb_owns && pend[bus.wb_rd]) waw = 1;
                if (pop) begin
                    head = q.pop_front();
                    if (head.rd != 0) pend[head.rd] = 0;
                end
                if (issue_valid && issue_rd != 0) pend[issue_rd] = 1;
                if (bus.mdu_valid && size0 < DEPTH)
                    q.push_back('{rd: int'(bus.mdu_rd), data: bus.mdu_data});
                if (size0 == 0 || pop) starve = 0;
                else if (starve < STARVE_LIMIT) starve++;
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
